// File: rtl/core_pkg.sv
// Shared core constants and types: datapath widths, ALU op classes and the
// per-instruction control bundle carried down the pipeline.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_RTYPE = 2'd2,
    ALU_ITYPE = 2'd3
  } aluop_e;

  typedef struct packed {
    logic   aluSrc;
    logic   regWrite;
    logic   memRead;
    logic   memWrite;
    logic   memtoReg;
    aluop_e aluOp;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

  // A bubble kills every side effect but leaves the operand-shaping bits
  // alone, so they do not toggle through the EX datapath.
  function automatic ctrl_t bubbleCtrl(input ctrl_t c);
    ctrl_t r;
    r          = c;
    r.regWrite = BUBBLE_CTRL.regWrite;
    r.memRead  = BUBBLE_CTRL.memRead;
    r.memWrite = BUBBLE_CTRL.memWrite;
    r.memtoReg = BUBBLE_CTRL.memtoReg;
    return r;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: a load in EX whose destination is read by the
// instruction in ID. x0 and unused source operands never match.
module load_use_detect #(
  parameter int AW = 5
) (
  input  logic          exMemRead,
  input  logic          exValid,
  input  logic [AW-1:0] exRd,
  input  logic          idValid,
  input  logic [AW-1:0] idRs1,
  input  logic [AW-1:0] idRs2,
  input  logic          idRs1Use,
  input  logic          idRs2Use,
  output logic          hz
);

  logic rs1Hit, rs2Hit;

  assign rs1Hit = idRs1Use && (idRs1 == exRd);
  assign rs2Hit = idRs2Use && (idRs2 == exRd);
  assign hz     = exMemRead && exValid && (exRd != '0) && idValid && (rs1Hit || rs2Hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and memory
// stall freeze. Optional bubble counter under `ID_EX_BUBBLE_CNT_EN.
module id_ex_stage #(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int REG_AW = core_pkg::REG_AW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_ID_i,
  input  logic [REG_AW-1:0] RS1addr_ID_i,
  input  logic [REG_AW-1:0] RS2addr_ID_i,
  input  logic [REG_AW-1:0] RDaddr_ID_i,
  input  logic              RS1use_ID_i,
  input  logic              RS2use_ID_i,
  input  logic [XLEN-1:0]   RS1data_ID_i,
  input  logic [XLEN-1:0]   RS2data_ID_i,
  input  logic [XLEN-1:0]   Imm_ID_i,
  input  logic [XLEN-1:0]   PC_ID_i,
  input  logic [9:0]        funct_ID_i,
  input  logic [1:0]        ALUOp_ID_i,
  input  logic              ALUSrc_ID_i,
  input  logic              RegWrite_ID_i,
  input  logic              MemRead_ID_i,
  input  logic              MemWrite_ID_i,
  input  logic              MemtoReg_ID_i,
  input  logic              Flush_i,
  input  logic              MemStall_i,
  output logic              valid_EX_o,
  output logic [REG_AW-1:0] RS1addr_EX_o,
  output logic [REG_AW-1:0] RS2addr_EX_o,
  output logic [REG_AW-1:0] RDaddr_EX_o,
  output logic              RS1use_EX_o,
  output logic              RS2use_EX_o,
  output logic [XLEN-1:0]   RS1data_EX_o,
  output logic [XLEN-1:0]   RS2data_EX_o,
  output logic [XLEN-1:0]   Imm_EX_o,
  output logic [XLEN-1:0]   PC_EX_o,
  output logic [9:0]        funct_EX_o,
  output logic [1:0]        ALUOp_EX_o,
  output logic              ALUSrc_EX_o,
  output logic              RegWrite_EX_o,
  output logic              MemRead_EX_o,
  output logic              MemWrite_EX_o,
  output logic              MemtoReg_EX_o,
  output logic              Stall_o,
  output logic              NoOp_o
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [31:0]       BubbleCnt_o
`endif
);

  import core_pkg::*;

  ctrl_t ctrlId, ctrlEx;
  logic  hz, bubble;

  assign ctrlId = '{aluSrc:   ALUSrc_ID_i,
                    regWrite: RegWrite_ID_i,
                    memRead:  MemRead_ID_i,
                    memWrite: MemWrite_ID_i,
                    memtoReg: MemtoReg_ID_i,
                    aluOp:    aluop_e'(ALUOp_ID_i)};

  load_use_detect #(.AW(REG_AW)) uHz (
    .exMemRead (ctrlEx.memRead),
    .exValid   (valid_EX_o),
    .exRd      (RDaddr_EX_o),
    .idValid   (valid_ID_i),
    .idRs1     (RS1addr_ID_i),
    .idRs2     (RS2addr_ID_i),
    .idRs1Use  (RS1use_ID_i),
    .idRs2Use  (RS2use_ID_i),
    .hz        (hz)
  );

  // Flush wins over hz but both give the same single bubble; Stall_o still
  // follows hz since the fetch redirect makes the IF/ID hold irrelevant.
  assign bubble  = Flush_i || hz;
  assign Stall_o = hz && !MemStall_i;
  assign NoOp_o  = rst_i && !MemStall_i && bubble;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_EX_o   <= 1'b0;
      RS1addr_EX_o <= '0;
      RS2addr_EX_o <= '0;
      RDaddr_EX_o  <= '0;
      RS1use_EX_o  <= 1'b0;
      RS2use_EX_o  <= 1'b0;
      RS1data_EX_o <= '0;
      RS2data_EX_o <= '0;
      Imm_EX_o     <= '0;
      PC_EX_o      <= '0;
      funct_EX_o   <= '0;
      ctrlEx       <= BUBBLE_CTRL;
    end else if (!MemStall_i) begin
      if (bubble) begin
        valid_EX_o <= 1'b0;
        ctrlEx     <= bubbleCtrl(ctrlEx);
      end else begin
        valid_EX_o   <= valid_ID_i;
        RS1addr_EX_o <= RS1addr_ID_i;
        RS2addr_EX_o <= RS2addr_ID_i;
        RDaddr_EX_o  <= RDaddr_ID_i;
        RS1use_EX_o  <= RS1use_ID_i;
        RS2use_EX_o  <= RS2use_ID_i;
        RS1data_EX_o <= RS1data_ID_i;
        RS2data_EX_o <= RS2data_ID_i;
        Imm_EX_o     <= Imm_ID_i;
        PC_EX_o      <= PC_ID_i;
        funct_EX_o   <= funct_ID_i;
        ctrlEx       <= ctrlId;
      end
    end
  end

  assign ALUOp_EX_o    = ctrlEx.aluOp;
  assign ALUSrc_EX_o   = ctrlEx.aluSrc;
  assign RegWrite_EX_o = ctrlEx.regWrite;
  assign MemRead_EX_o  = ctrlEx.memRead;
  assign MemWrite_EX_o = ctrlEx.memWrite;
  assign MemtoReg_EX_o = ctrlEx.memtoReg;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubbleCnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      bubbleCnt <= '0;
    else if (NoOp_o && (bubbleCnt != '1))
      bubbleCnt <= bubbleCnt + 32'd1;
  end

  assign BubbleCnt_o = bubbleCnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scenarios plus randomized traffic against a cycle-level model of
// the ID/EX register's capture / bubble / freeze rules.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1Use, rs2Use;
    logic [31:0] rs1Data, rs2Data, imm, pc;
    logic [9:0]  funct;
    logic [1:0]  aluOp;
    logic        aluSrc, regWrite, memRead, memWrite, memtoReg;
  } id_t;

  logic clk = 1'b0;
  logic rstN = 1'b1;
  logic flush = 1'b0, memStall = 1'b0;
  id_t  id = '0;
  id_t  obs, ex;
  logic stallO, noopO;
  logic hz, expStall, expNoop;
  logic [31:0] cnt;
  int   nTests = 0, nFail = 0;

  logic        vEx, u1Ex, u2Ex, srcEx, rwEx, mrEx, mwEx, m2rEx;
  logic [4:0]  a1Ex, a2Ex, rdEx;
  logic [31:0] d1Ex, d2Ex, immEx, pcEx;
  logic [9:0]  fnEx;
  logic [1:0]  opEx;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubbleCnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rstN), .valid_ID_i(id.valid),
    .RS1addr_ID_i(id.rs1), .RS2addr_ID_i(id.rs2), .RDaddr_ID_i(id.rd),
    .RS1use_ID_i(id.rs1Use), .RS2use_ID_i(id.rs2Use),
    .RS1data_ID_i(id.rs1Data), .RS2data_ID_i(id.rs2Data), .Imm_ID_i(id.imm), .PC_ID_i(id.pc),
    .funct_ID_i(id.funct), .ALUOp_ID_i(id.aluOp), .ALUSrc_ID_i(id.aluSrc),
    .RegWrite_ID_i(id.regWrite), .MemRead_ID_i(id.memRead), .MemWrite_ID_i(id.memWrite),
    .MemtoReg_ID_i(id.memtoReg), .Flush_i(flush), .MemStall_i(memStall),
    .valid_EX_o(vEx), .RS1addr_EX_o(a1Ex), .RS2addr_EX_o(a2Ex), .RDaddr_EX_o(rdEx),
    .RS1use_EX_o(u1Ex), .RS2use_EX_o(u2Ex), .RS1data_EX_o(d1Ex), .RS2data_EX_o(d2Ex),
    .Imm_EX_o(immEx), .PC_EX_o(pcEx), .funct_EX_o(fnEx), .ALUOp_EX_o(opEx),
    .ALUSrc_EX_o(srcEx), .RegWrite_EX_o(rwEx), .MemRead_EX_o(mrEx), .MemWrite_EX_o(mwEx),
    .MemtoReg_EX_o(m2rEx), .Stall_o(stallO), .NoOp_o(noopO)
`ifdef ID_EX_BUBBLE_CNT_EN
    , .BubbleCnt_o(bubbleCnt)
`endif
  );

  assign obs = {vEx, a1Ex, a2Ex, rdEx, u1Ex, u2Ex, d1Ex, d2Ex, immEx, pcEx, fnEx, opEx,
                srcEx, rwEx, mrEx, mwEx, m2rEx};

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected behaviour from the block's rules, evaluated on the current EX
  // contents and the inputs presented this cycle.
  task automatic checkModel();
    hz = ex.memRead && ex.valid && (ex.rd != 0) && id.valid &&
         ((id.rs1Use && id.rs1 == ex.rd) || (id.rs2Use && id.rs2 == ex.rd));
    expStall = hz && !memStall;
    expNoop  = !memStall && (flush || hz);
    chk("ex_regs", obs, ex);
    chk("stall", stallO, expStall);
    chk("noop", noopO, expNoop);
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("bubble_cnt", bubbleCnt, cnt);
`endif
  endtask

  task automatic updateModel();
    if (!memStall) begin
      if (flush || hz) begin
        ex.valid = 0; ex.regWrite = 0; ex.memRead = 0; ex.memWrite = 0; ex.memtoReg = 0;
        if (cnt != 32'hFFFF_FFFF) cnt = cnt + 1;
      end else begin
        ex = id;
      end
    end
  endtask

  task automatic step();
    @(negedge clk); checkModel();
    @(posedge clk); updateModel(); #1;
  endtask

  function automatic id_t mkInstr(input logic [4:0] rs1, rs2, rd, input logic u1, u2,
                                  input logic mr, rw, mw, input logic [31:0] pc);
    id_t r = '0;
    r.valid = 1; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.rs1Use = u1; r.rs2Use = u2;
    r.memRead = mr; r.memtoReg = mr; r.regWrite = rw; r.memWrite = mw; r.aluSrc = mr | mw;
    r.rs1Data = $urandom; r.rs2Data = $urandom; r.imm = $urandom; r.pc = pc;
    r.funct = 10'h05; r.aluOp = 2'd2;
    return r;
  endfunction

  function automatic id_t rndInstr();
    id_t r;
    r.valid = ($urandom_range(0, 7) != 0);
    r.rs1 = 5'($urandom_range(0, 3)); r.rs2 = 5'($urandom_range(0, 3)); r.rd = 5'($urandom_range(0, 3));
    r.rs1Use = 1'($urandom); r.rs2Use = 1'($urandom);
    r.rs1Data = $urandom; r.rs2Data = $urandom; r.imm = $urandom; r.pc = $urandom;
    r.funct = 10'($urandom); r.aluOp = 2'($urandom);
    r.aluSrc = 1'($urandom); r.regWrite = 1'($urandom); r.memRead = 1'($urandom);
    r.memWrite = 1'($urandom); r.memtoReg = 1'($urandom);
    return r;
  endfunction

  id_t snap;

  initial begin
    ex = '0; cnt = 0;
    // Reset asserted mid-cycle with live data and a flush on the inputs.
    id = mkInstr(5'd1, 5'd2, 5'd3, 1, 1, 0, 1, 0, 32'h100);
    flush = 1;
    #2 rstN = 0;
    #1;
    chk("rst_regs", obs, 192'd0);
    chk("rst_stall", stallO, 1'b0);
    chk("rst_noop", noopO, 1'b0);
    @(posedge clk); #2;
    flush = 0; rstN = 1;
    step();
    chk("rst_first_pc", pcEx, 32'h100);
    chk("rst_first_valid", vEx, 1'b1);

    // Load-use: lw x5 then add x6,x5,x7.
    id = mkInstr(5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0, 32'h104); step();
    id = mkInstr(5'd5, 5'd7, 5'd6, 1, 1, 0, 1, 0, 32'h108); #1;
    chk("lu_stall", stallO, 1'b1);
    chk("lu_noop", noopO, 1'b1);
    step();
    chk("lu_bub_valid", vEx, 1'b0);
    chk("lu_bub_rw", rwEx, 1'b0);
    chk("lu_after_stall", stallO, 1'b0);
    step();
    chk("lu_cap_rs1", a1Ex, 5'd5);
    chk("lu_cap_valid", vEx, 1'b1);

    // lw x5 then lui x5: no source use, no stall.
    id = mkInstr(5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0, 32'h10c); step();
    id = mkInstr(5'd5, 5'd5, 5'd5, 0, 0, 0, 1, 0, 32'h110); #1;
    chk("lui_stall", stallO, 1'b0);
    step();
    chk("lui_cap_pc", pcEx, 32'h110);
    // lw x0 then a reader of x0.
    id = mkInstr(5'd2, 5'd0, 5'd0, 1, 0, 1, 1, 0, 32'h114); step();
    id = mkInstr(5'd0, 5'd0, 5'd8, 1, 1, 0, 1, 0, 32'h118); #1;
    chk("x0_stall", stallO, 1'b0);
    step();

    // Flush on a store, then flush together with a hazard.
    id = mkInstr(5'd1, 5'd2, 5'd0, 1, 1, 0, 0, 1, 32'h11c); flush = 1; step();
    chk("fl_memwrite", mwEx, 1'b0);
    chk("fl_valid", vEx, 1'b0);
    flush = 0;
    id = mkInstr(5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0, 32'h120); step();
    id = mkInstr(5'd5, 5'd1, 5'd9, 1, 1, 0, 1, 0, 32'h124); flush = 1; #1;
    chk("flhz_stall", stallO, 1'b1);
    chk("flhz_noop", noopO, 1'b1);
    step();
    flush = 0; #1;
    chk("flhz_single", stallO, 1'b0);
    step();

    // Memory stall during a hazard freezes everything.
    id = mkInstr(5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0, 32'h128); step();
    id = mkInstr(5'd1, 5'd5, 5'd9, 1, 1, 0, 1, 0, 32'h12c); memStall = 1; #1;
    snap = obs;
    repeat (3) step();
    chk("ms_frozen", obs, snap);
    chk("ms_stall", stallO, 1'b0);
    chk("ms_noop", noopO, 1'b0);
    memStall = 0; #1;
    chk("ms_rel_stall", stallO, 1'b1);
    step();
    chk("ms_bub_valid", vEx, 1'b0);
    step();
    chk("ms_cap_rs2", a2Ex, 5'd5);

    // Reset during a pending load-use stall.
    id = mkInstr(5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0, 32'h130); step();
    id = mkInstr(5'd5, 5'd0, 5'd6, 1, 0, 0, 1, 0, 32'h100); #2;
    rstN = 0; #1;
    chk("rst2_regs", obs, 192'd0);
    chk("rst2_stall", stallO, 1'b0);
    ex = '0; cnt = 0;
    rstN = 1;
    step();
    chk("rst2_cap_pc", pcEx, 32'h100);

    // Randomized traffic; ID is held while a load-use stall is requested.
    for (int i = 0; i < 400; i++) begin
      if (!expStall) id = rndInstr();
      flush    = ($urandom_range(0, 7) == 0);
      memStall = ($urandom_range(0, 5) == 0);
      step();
    end
    flush = 0; memStall = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
